depkt_flit_arbiter: RTL and testbench

//  Shares one depacketizer between N_PORTS flit sources with round-robin, packet-locked (wormhole) arbitration.

---
 rtl/depkt_pkg.sv | 24 ++
 rtl/depkt_flit_arbiter_rr_picker.sv | 46 ++++
 rtl/depkt_flit_arbiter.sv | 179 +++++++++++++++++
 tb/tb_depkt_flit_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/depkt_pkg.sv
// depkt_pkg
//   Definitions shared by the flit arbiter and its round-robin picker:
//   flit-type codes, the arbiter FSM state type and a modulo increment
//   helper used to advance the round-robin pointer.
package depkt_pkg;

  localparam logic [1:0] FT_RSVD = 2'b00;
  localparam logic [1:0] FT_HEAD = 2'b01;
  localparam logic [1:0] FT_BODY = 2'b10;
  localparam logic [1:0] FT_TAIL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BODY  = 2'd1,
    TAIL  = 2'd2,
    ISSUE = 2'd3
  } state_t;

  // (idx + 1) mod n without a divider
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/depkt_flit_arbiter_rr_picker.sv
// rr_picker
//   Combinational round-robin picker: returns the first asserted request
//   found when scanning i_ptr, i_ptr+1, ... (mod N).
// Ports
//   i_req    N-bit request vector
//   i_ptr    highest-priority index for this cycle
//   o_grant  one-hot grant (all zero when no request)
//   o_idx    index of the granted request
//   o_any    at least one request present
module rr_picker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_grant,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  int         w_j;
  logic [W-1:0] w_k_idx;

  // Scan from lowest to highest priority; the last hit written wins, which
  // leaves the request closest to i_ptr in o_idx.
  always_comb begin
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = 0;
    w_k_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j     = (int'(i_ptr) + k) % N;
      w_k_idx = W'(w_j);
      if (i_req[w_k_idx]) begin
        o_idx = w_k_idx;
        o_any = 1'b1;
      end
    end
  end

  always_comb begin
    o_grant = '0;
    if (o_any) o_grant[o_idx] = 1'b1;
  end

endmodule

// File: rtl/depkt_flit_arbiter.sv
// depkt_flit_arbiter
//   Round-robin, packet-locked arbiter sharing one depacketizer between
//   N_PORTS flit sources. Collects HEAD/BODY/TAIL from the owning source
//   into HF/BF/TF and offers the packet with a pkt_valid/pkt_ready handshake.
//   Out-of-sequence flits are dropped (err_seq), stalled packets aborted
//   (err_tmo).
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   in_valid/type/flit    per-source flit stream (port i at slice i)
//   in_ready              per-source accept, at most one bit high
//   HF, BF, TF            captured head/body/tail flits
//   pkt_valid, pkt_ready  packet handshake to the depacketizer
//   owner                 source currently granted
//   err_seq, err_tmo      single-cycle error pulses
//   pkt_count             completed packets (wraps)
//
// state | meaning
// IDLE  | arbitrate among sources, waiting for a HEAD
// BODY  | owner locked, waiting for BODY
// TAIL  | owner locked, waiting for TAIL
// ISSUE | packet held, waiting for pkt_ready
module depkt_flit_arbiter
  import depkt_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int FLIT_W  = 256,
  parameter int TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_PORTS-1:0]          in_valid,
  input  logic [2*N_PORTS-1:0]        in_type,
  input  logic [FLIT_W*N_PORTS-1:0]   in_flit,
  output logic [N_PORTS-1:0]          in_ready,
  output logic [FLIT_W-1:0]           HF,
  output logic [FLIT_W-1:0]           BF,
  output logic [FLIT_W-1:0]           TF,
  output logic                        pkt_valid,
  input  logic                        pkt_ready,
  output logic [$clog2(N_PORTS)-1:0]  owner,
  output logic                        err_seq,
  output logic                        err_tmo,
  output logic [15:0]                 pkt_count
);

  localparam int OW = $clog2(N_PORTS);
  localparam int TW = $clog2(TIMEOUT);

  state_t             r_state;
  logic [FLIT_W-1:0]  r_hf, r_bf, r_tf;
  logic               r_pkt_valid;
  logic [OW-1:0]      r_owner, r_rr_ptr;
  logic               r_err_seq, r_err_tmo;
  logic [15:0]        r_pkt_count;
  logic [TW-1:0]      r_tmo_cnt;

  logic [N_PORTS-1:0] w_win_grant, w_owner_oh;
  logic [OW-1:0]      w_win_idx, w_sel, w_owner_next, w_win_next;
  logic               w_win_any, w_xfer;
  logic [1:0]         w_sel_type;
  logic [FLIT_W-1:0]  w_sel_flit;

  rr_picker #(.N(N_PORTS), .W(OW)) u_rr_picker (
    .i_req   (in_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_win_grant),
    .o_idx   (w_win_idx),
    .o_any   (w_win_any)
  );

  // The arbitration winner is only relevant in IDLE; afterwards the owner is locked.
  assign w_sel        = (r_state == IDLE) ? w_win_idx : r_owner;
  assign w_owner_next = OW'(rr_next(int'(r_owner), N_PORTS));
  assign w_win_next   = OW'(rr_next(int'(w_win_idx), N_PORTS));

  always_comb begin
    w_sel_flit = '0;
    w_sel_type = FT_RSVD;
    for (int i = 0; i < N_PORTS; i++) begin
      if (w_sel == OW'(i)) begin
        w_sel_flit = in_flit[i*FLIT_W +: FLIT_W];
        w_sel_type = in_type[i*2 +: 2];
      end
    end
  end

  always_comb begin
    w_owner_oh          = '0;
    w_owner_oh[r_owner] = 1'b1;
  end

  always_comb begin
    case (r_state)
      IDLE:       in_ready = w_win_grant;
      BODY, TAIL: in_ready = w_owner_oh;
      default:    in_ready = '0;
    endcase
  end

  assign w_xfer = |(in_ready & in_valid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_hf        <= '0;
      r_bf        <= '0;
      r_tf        <= '0;
      r_pkt_valid <= 1'b0;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_err_seq   <= 1'b0;
      r_err_tmo   <= 1'b0;
      r_pkt_count <= '0;
      r_tmo_cnt   <= '0;
    end else begin
      r_err_seq <= 1'b0;
      r_err_tmo <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_xfer && w_win_any) begin
            if (w_sel_type == FT_HEAD) begin
              r_hf      <= w_sel_flit;
              r_owner   <= w_win_idx;
              r_tmo_cnt <= '0;
              r_state   <= BODY;
            end else begin
              r_err_seq <= 1'b1;
              r_rr_ptr  <= w_win_next;
            end
          end
        end
        BODY, TAIL: begin
          if (w_xfer) begin
            r_tmo_cnt <= '0;
            if (r_state == BODY && w_sel_type == FT_BODY) begin
              r_bf    <= w_sel_flit;
              r_state <= TAIL;
            end else if (r_state == TAIL && w_sel_type == FT_TAIL) begin
              r_tf        <= w_sel_flit;
              r_pkt_valid <= 1'b1;
              r_state     <= ISSUE;
            end else begin
              r_err_seq <= 1'b1;
              r_rr_ptr  <= w_owner_next;
              r_state   <= IDLE;
            end
          end else if (r_tmo_cnt == TW'(TIMEOUT - 1)) begin
            r_err_tmo <= 1'b1;
            r_tmo_cnt <= '0;
            r_rr_ptr  <= w_owner_next;
            r_state   <= IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        ISSUE: begin
          // No bypass to arbitration: IDLE is entered for at least one cycle.
          if (pkt_ready) begin
            r_pkt_valid <= 1'b0;
            r_pkt_count <= r_pkt_count + 16'd1;
            r_rr_ptr    <= w_owner_next;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign HF        = r_hf;
  assign BF        = r_bf;
  assign TF        = r_tf;
  assign pkt_valid = r_pkt_valid;
  assign owner     = r_owner;
  assign err_seq   = r_err_seq;
  assign err_tmo   = r_err_tmo;
  assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_depkt_flit_arbiter.sv
module tb_depkt_flit_arbiter;

  localparam int N   = 4;
  localparam int FW  = 256;
  localparam int TMO = 64;
  localparam logic [1:0] T_H = 2'b01;
  localparam logic [1:0] T_B = 2'b10;
  localparam logic [1:0] T_T = 2'b11;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [N-1:0]      in_valid = '0;
  logic [2*N-1:0]    in_type = '0;
  logic [FW*N-1:0]   in_flit = '0;
  logic              pkt_ready = 1'b0;
  logic [N-1:0]      in_ready;
  logic [FW-1:0]     HF, BF, TF;
  logic              pkt_valid;
  logic [1:0]        owner;
  logic              err_seq, err_tmo;
  logic [15:0]       pkt_count;

  always #5 clk = ~clk;

  depkt_flit_arbiter #(.N_PORTS(N), .FLIT_W(FW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_type(in_type),
    .in_flit(in_flit), .in_ready(in_ready), .HF(HF), .BF(BF), .TF(TF),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .owner(owner),
    .err_seq(err_seq), .err_tmo(err_tmo), .pkt_count(pkt_count)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a source owns the depacketizer while its collected
  // flit list is non-empty; three flits in H,B,T order form a packet.
  typedef struct { logic [FW-1:0] h; logic [FW-1:0] b; logic [FW-1:0] t; int own; int cnt; } pkt_t;
  typedef struct { int at; bit tmo; } err_t;

  int            m_ptr, m_owner, m_idle, m_count, m_abort;
  bit            m_hold;
  logic [FW-1:0] m_col[$];
  logic [N-1:0]  m_acc;
  pkt_t          pq[$];
  err_t          eq[$];
  logic [N-1:0]  last_ready;

  function automatic logic [N-1:0] exp_grant(input logic [N-1:0] v);
    logic [N-1:0] g;
    g = '0;
    if (m_hold) return g;
    if (m_col.size() > 0) begin
      g[m_owner] = 1'b1;
      return g;
    end
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) begin
        g[(m_ptr + k) % N] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  function automatic logic [FW-1:0] rnd_flit();
    logic [FW-1:0] r;
    for (int i = 0; i < FW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_clear();
    m_ptr = 0; m_owner = 0; m_idle = 0; m_count = 0; m_hold = 0; m_abort = -1;
    m_col.delete(); pq.delete(); eq.delete();
  endtask

  task automatic push_err(input bit tmo);
    err_t e;
    e.at = cyc + 1;
    e.tmo = tmo;
    eq.push_back(e);
  endtask

  task automatic abort_pkt();
    m_abort = m_owner;
    m_col.delete();
    m_ptr = (m_owner + 1) % N;
    m_idle = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] g;
    logic [1:0]   ty, need;
    int           w;
    pkt_t         p;
    g = exp_grant(in_valid);
    m_acc = g & in_valid;
    m_abort = -1;
    w = 0;
    for (int i = 0; i < N; i++) if (m_acc[i]) w = i;
    if (m_hold) begin
      if (pkt_ready) begin
        m_hold = 0;
        m_col.delete();
        m_count = (m_count + 1) % 65536;
        m_ptr = (m_owner + 1) % N;
      end
    end else if (m_col.size() == 0) begin
      if (m_acc != 0) begin
        ty = in_type[2*w +: 2];
        if (ty == T_H) begin
          m_col.push_back(in_flit[w*FW +: FW]);
          m_owner = w;
          m_idle = 0;
        end else begin
          push_err(0);
          m_ptr = (w + 1) % N;
          m_abort = w;
        end
      end
    end else begin
      need = (m_col.size() == 1) ? T_B : T_T;
      if (in_valid[m_owner]) begin
        m_idle = 0;
        ty = in_type[2*m_owner +: 2];
        if (ty == need) begin
          m_col.push_back(in_flit[m_owner*FW +: FW]);
          if (m_col.size() == 3) begin
            m_hold = 1;
            p.h = m_col[0]; p.b = m_col[1]; p.t = m_col[2];
            p.own = m_owner; p.cnt = m_count;
            pq.push_back(p);
          end
        end else begin
          push_err(0);
          abort_pkt();
        end
      end else if (m_idle == TMO - 1) begin
        push_err(1);
        abort_pkt();
      end else begin
        m_idle++;
      end
    end
    cyc++;
  endtask

  task automatic run_cycle(input logic [N-1:0] v, input logic [2*N-1:0] t,
                           input logic [FW*N-1:0] f, input logic pr);
    @(negedge clk);
    in_valid = v; in_type = t; in_flit = f; pkt_ready = pr;
    #1;
    last_ready = in_ready;
    chk("in_ready", in_ready, exp_grant(v));
    chk("pkt_valid", pkt_valid, m_hold);
    if (m_col.size() > 0) chk("owner", owner, m_owner[1:0]);
    if (m_hold) begin
      chk("HF_hold", HF, m_col[0]);
      chk("BF_hold", BF, m_col[1]);
      chk("TF_hold", TF, m_col[2]);
    end
    @(posedge clk);
    model_step();
  endtask

  task automatic one(input int p, input logic [1:0] ty, input logic [FW-1:0] fl, input logic pr);
    logic [N-1:0]    v;
    logic [2*N-1:0]  t;
    logic [FW*N-1:0] f;
    v = '0; t = '0; f = '0;
    v[p] = 1'b1;
    t[2*p +: 2] = ty;
    f[p*FW +: FW] = fl;
    run_cycle(v, t, f, pr);
  endtask

  task automatic heads(input logic [N-1:0] v, input logic pr);
    logic [2*N-1:0]  t;
    logic [FW*N-1:0] f;
    for (int p = 0; p < N; p++) begin
      t[2*p +: 2] = T_H;
      f[p*FW +: FW] = rnd_flit();
    end
    run_cycle(v, t, f, pr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = '0;
    #4;
    reset = 1'b1;
    model_clear();
    #1;
    chk("rst_in_ready", in_ready, '0);
    chk("rst_pkt_valid", pkt_valid, 1'b0);
    chk("rst_owner", owner, 2'd0);
    chk("rst_HF", HF, '0);
    chk("rst_BF", BF, '0);
    chk("rst_TF", TF, '0);
    chk("rst_pkt_count", pkt_count, 16'd0);
    chk("rst_err", {err_seq, err_tmo}, 2'b00);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: pops expected packets at each handshake and expected error
  // pulses at the cycle they are due.
  initial begin
    pkt_t p;
    err_t e;
    bit   xs, xt;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        xs = 0; xt = 0;
        if (eq.size() > 0 && eq[0].at == cyc) begin
          e = eq.pop_front();
          xs = !e.tmo;
          xt = e.tmo;
        end
        if (xs || xt || err_seq || err_tmo) begin
          chk("err_seq", err_seq, xs);
          chk("err_tmo", err_tmo, xt);
        end
        if (pkt_valid && pkt_ready) begin
          if (pq.size() == 0) begin
            chk("pkt_unexpected", 1'b1, 1'b0);
          end else begin
            p = pq.pop_front();
            chk("pkt_HF", HF, p.h);
            chk("pkt_BF", BF, p.b);
            chk("pkt_TF", TF, p.t);
            chk("pkt_owner", owner, p.own[1:0]);
            chk("pkt_count", pkt_count, p.cnt[15:0]);
          end
        end
      end
    end
  end

  bit         pv[N];
  int         pseq[N];
  logic [1:0] pty[N];
  logic [FW-1:0] pfl[N];

  initial begin
    logic [N-1:0]    v;
    logic [2*N-1:0]  t;
    logic [FW*N-1:0] f;
    model_clear();
    do_reset();

    // 1: single packet from port 2
    one(2, T_H, {32{8'hA1}}, 1'b1);
    one(2, T_B, {32{8'hB2}}, 1'b1);
    one(2, T_T, {32{8'hC3}}, 1'b1);
    run_cycle('0, '0, '0, 1'b1);
    run_cycle('0, '0, '0, 1'b1);
    chk("t1_count", pkt_count, 16'd1);
    chk("t1_owner", owner, 2'd2);

    // 2: all ports hold HEAD
    do_reset();
    repeat (12) heads(4'hF, 1'b1);

    // 3: H then H from port 0
    do_reset();
    one(0, T_H, rnd_flit(), 1'b1);
    one(0, T_H, rnd_flit(), 1'b1);
    heads(4'hF, 1'b1);
    chk("t3_rr", last_ready, 4'b0010);

    // 4: timeout after head from port 1
    do_reset();
    one(1, T_H, rnd_flit(), 1'b1);
    repeat (TMO) heads(4'b1101, 1'b1);
    heads(4'hF, 1'b1);
    chk("t4_next", last_ready, 4'b0100);

    // 5: long backpressure
    do_reset();
    one(3, T_H, rnd_flit(), 1'b0);
    one(3, T_B, rnd_flit(), 1'b0);
    one(3, T_T, rnd_flit(), 1'b0);
    repeat (TMO + 6) heads(4'hF, 1'b0);
    run_cycle('0, '0, '0, 1'b1);
    run_cycle('0, '0, '0, 1'b1);
    chk("t5_count", pkt_count, 16'd1);

    // 6: reset while in TAIL, then a fresh packet
    do_reset();
    one(0, T_H, rnd_flit(), 1'b1);
    one(0, T_B, rnd_flit(), 1'b1);
    do_reset();
    one(1, T_H, rnd_flit(), 1'b1);
    one(1, T_B, rnd_flit(), 1'b1);
    one(1, T_T, rnd_flit(), 1'b1);
    run_cycle('0, '0, '0, 1'b1);
    run_cycle('0, '0, '0, 1'b1);
    chk("t6_count", pkt_count, 16'd1);

    // Randomized traffic: each source walks H,B,T with occasional bad types and stalls
    do_reset();
    for (int p = 0; p < N; p++) begin pv[p] = 0; pseq[p] = 0; end
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < N; p++) begin
        if (!pv[p]) begin
          if ($urandom % 3 != 0) begin
            pv[p] = 1;
            pty[p] = ($urandom % 12 == 0) ? 2'($urandom % 4) : 2'(pseq[p] + 1);
            pfl[p] = rnd_flit();
          end
        end else if ($urandom % 10 == 0) begin
          pv[p] = 0;
        end
        v[p] = pv[p];
        t[2*p +: 2] = pty[p];
        f[p*FW +: FW] = pfl[p];
      end
      run_cycle(v, t, f, ($urandom % 4 != 0));
      for (int p = 0; p < N; p++) begin
        if (m_acc[p]) begin
          pv[p] = 0;
          pseq[p] = (m_abort == p) ? 0 : (pseq[p] + 1) % 3;
        end else if (m_abort == p) begin
          pseq[p] = 0;
        end
      end
    end
    repeat (4) run_cycle('0, '0, '0, 1'b1);
    chk("pkt_queue_empty", pq.size(), 0);
    chk("err_queue_empty", eq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
